// File: rtl/sng_pkg.sv
// Shared definitions for the stochastic number generator and its adder.
// Holds the default channel/precision constants, state encoding and bit-reverse helper.
package sng_pkg;

  localparam int unsigned SngInum     = 8;
  localparam int unsigned SngLogInum  = 3;
  localparam int unsigned SngBitwidth = 8;

  typedef logic [0:0] sng_state_t;

  localparam sng_state_t StIdle = 1'b0;
  localparam sng_state_t StRun  = 1'b1;

  // Reverse the low `width` bits of val. Bits above `width` must be zero.
  // The result occupies the low `width` bits.
  function automatic logic [31:0] bitrev(input logic [31:0] val, input int unsigned width);
    logic [31:0] rev;
    rev = {<<{val}};
    return rev >> (32 - width);
  endfunction

endpackage

// File: rtl/vdc_rng.sv
// Van der Corput sequence source: one shared counter and per-channel phase-shifted
// bit-reversed values.
module vdc_rng
  import sng_pkg::*;
#(
  parameter int unsigned INUM     = SngInum,
  parameter int unsigned BITWIDTH = SngBitwidth
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     clr_i,
  output logic [BITWIDTH-1:0]      cnt_o,
  output logic [INUM*BITWIDTH-1:0] rand_o
);

  localparam int unsigned Stride = (1 << BITWIDTH) / INUM;

  logic [BITWIDTH-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

  // Channels are spread evenly around the period so their sequences stay decorrelated.
  for (genvar g = 0; g < INUM; g++) begin : g_chan
    localparam logic [BITWIDTH-1:0] Offset = BITWIDTH'(g * Stride);
    logic [BITWIDTH-1:0] phase;
    assign phase = cnt_q + Offset;
    assign rand_o[g*BITWIDTH +: BITWIDTH] = BITWIDTH'(bitrev(32'(phase), BITWIDTH));
  end

endmodule

// File: rtl/sng_array.sv
// Multi-channel stochastic number generator feeding the approximate parallel counter adder.
// Emits one unipolar bit per channel per cycle for 2^BITWIDTH cycles after a start.
module sng_array
  import sng_pkg::*;
#(
  parameter int unsigned INUM     = SngInum,
  parameter int unsigned LOGINUM  = SngLogInum,
  parameter int unsigned BITWIDTH = SngBitwidth
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     clr,
  input  logic [INUM*BITWIDTH-1:0] binIn,
  output logic [INUM-1:0]          out,
  output logic [LOGINUM-1:0]       randNum,
  output logic                     valid,
  output logic                     busy,
  output logic                     done
);

  localparam logic [BITWIDTH-1:0] CntMax = '1;

  sng_state_t                 state_d, state_q;
  logic [INUM*BITWIDTH-1:0]   op_d, op_q;
  logic [INUM-1:0]            out_d, out_q;
  logic [LOGINUM-1:0]         rand_num_d, rand_num_q;
  logic                       valid_d, valid_q;
  logic                       done_d, done_q;

  logic [BITWIDTH-1:0]        cnt;
  logic [INUM*BITWIDTH-1:0]   rand_vec;
  logic [INUM-1:0]            hit;
  logic                       launch;
  logic                       run;

  assign launch = (state_q == StIdle) && start && !clr;
  assign run    = (state_q == StRun) && !clr;

  vdc_rng #(
    .INUM     (INUM),
    .BITWIDTH (BITWIDTH)
  ) u_rng (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (run),
    .clr_i  (clr || launch),
    .cnt_o  (cnt),
    .rand_o (rand_vec)
  );

  for (genvar g = 0; g < INUM; g++) begin : g_cmp
    assign hit[g] = op_q[g*BITWIDTH +: BITWIDTH] > rand_vec[g*BITWIDTH +: BITWIDTH];
  end

  // Outputs default to zero so idle, abort and post-stream cycles all read as 0.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    out_d      = '0;
    rand_num_d = '0;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    if (clr) begin
      state_d = StIdle;
    end else if (state_q == StIdle) begin
      if (start) begin
        op_d    = binIn;
        state_d = StRun;
      end
    end else begin
      out_d      = hit;
      rand_num_d = LOGINUM'(bitrev(32'(cnt[LOGINUM-1:0]), LOGINUM));
      valid_d    = 1'b1;
      if (cnt == CntMax) begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= '0;
      out_q      <= '0;
      rand_num_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      out_q      <= out_d;
      rand_num_q <= rand_num_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  assign out     = out_q;
  assign randNum = rand_num_q;
  assign valid   = valid_q;
  assign busy    = (state_q == StRun);
  assign done    = done_q;

endmodule

// File: tb/tb_sng_array.sv
// Self-checking bench for sng_array at INUM=4, BITWIDTH=4 (16-cycle streams).
module tb_sng_array;

  localparam int unsigned INUM    = 4;
  localparam int unsigned LOGINUM = 2;
  localparam int unsigned BW      = 4;
  localparam int unsigned LEN     = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 clr;
  logic [INUM*BW-1:0]   binIn;
  logic [INUM-1:0]      out;
  logic [LOGINUM-1:0]   randNum;
  logic                 valid;
  logic                 busy;
  logic                 done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sng_array #(
    .INUM     (INUM),
    .LOGINUM  (LOGINUM),
    .BITWIDTH (BW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .clr     (clr),
    .binIn   (binIn),
    .out     (out),
    .randNum (randNum),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  // Reverse the low w bits of v by repeated division.
  function automatic int rev_bits(input int v, input int w);
    int r = 0;
    int x = v;
    for (int k = 0; k < w; k++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  function automatic logic [INUM*BW-1:0] pack(input int o[INUM]);
    logic [INUM*BW-1:0] r = '0;
    for (int i = 0; i < INUM; i++) r[i*BW +: BW] = BW'(o[i]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "/outs"}, 32'({out, randNum, valid, busy, done}), 32'd0);
  endtask

  // Entered and left on a negedge. Optional mid-stream poke, abort, async reset or restart.
  task automatic run_stream(input int op[INUM], input bit do_start, input int poke_at,
                            input int abort_at, input int reset_at, input bit restart,
                            input int rops[INUM], input string tag);
    int              ones[INUM];
    logic [INUM-1:0] exp_out;
    for (int i = 0; i < INUM; i++) ones[i] = 0;
    if (do_start) begin
      binIn = pack(op);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "/armed"}, 32'({valid, busy}), 32'b01);
    end
    for (int n = 0; n < int'(LEN); n++) begin
      @(negedge clk);
      start = 1'b0;
      for (int ch = 0; ch < int'(INUM); ch++)
        exp_out[ch] = op[ch] > rev_bits((n + ch * int'(LEN / INUM)) % int'(LEN), BW);
      check($sformatf("%s/valid n=%0d", tag, n), 32'(valid), 32'd1);
      check($sformatf("%s/busy n=%0d", tag, n), 32'(busy), 32'(n != int'(LEN) - 1));
      check($sformatf("%s/done n=%0d", tag, n), 32'(done), 32'(n == int'(LEN) - 1));
      check($sformatf("%s/out n=%0d", tag, n), 32'(out), 32'(exp_out));
      check($sformatf("%s/randNum n=%0d", tag, n), 32'(randNum),
            32'(rev_bits(n % int'(INUM), LOGINUM)));
      for (int ch = 0; ch < int'(INUM); ch++) ones[ch] += int'(out[ch]);
      if (n == poke_at) begin
        binIn = '1;
        start = 1'b1;
      end
      if (n == abort_at) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_zero({tag, "/abort"});
        return;
      end
      if (n == reset_at) begin
        #2 rst_n = 1'b0;
        #1 check_zero({tag, "/async_rst"});
        @(negedge clk);
        rst_n = 1'b1;
        check_zero({tag, "/rst_held"});
        @(negedge clk);
        check_zero({tag, "/rst_idle"});
        return;
      end
      if (n == int'(LEN) - 1 && restart) begin
        binIn = pack(rops);
        start = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "/after"}, 32'({out, randNum, valid, done}), 32'd0);
    check({tag, "/after_busy"}, 32'(busy), 32'(restart));
    for (int ch = 0; ch < int'(INUM); ch++)
      check($sformatf("%s/ones ch%0d", tag, ch), 32'(ones[ch]), 32'(op[ch]));
  endtask

  int a[INUM];
  int b[INUM];

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    clr   = 1'b0;
    binIn = INUM*BW'($urandom);
    @(negedge clk);
    check_zero("reset1");
    @(negedge clk);
    check_zero("reset2");
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check_zero("post_reset");

    a = '{8, 8, 8, 8};
    run_stream(a, 1'b1, -1, -1, -1, 1'b0, a, "seq8");
    check("seq8/gap", 32'(valid), 32'd0);

    a = '{0, 5, 11, 15};
    run_stream(a, 1'b1, -1, -1, -1, 1'b0, a, "density");

    // Start together with clr in idle must not launch.
    start = 1'b1;
    clr   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr   = 1'b0;
    check_zero("clr_over_start");

    for (int i = 0; i < int'(INUM); i++) begin
      a[i] = int'($urandom_range(0, 15));
      b[i] = int'($urandom_range(0, 15));
    end
    run_stream(a, 1'b1, 3, -1, -1, 1'b1, b, "isolate");
    run_stream(b, 1'b0, -1, -1, -1, 1'b0, b, "restart");

    for (int i = 0; i < int'(INUM); i++) a[i] = int'($urandom_range(0, 15));
    run_stream(a, 1'b1, -1, 5, -1, 1'b0, a, "abort");
    run_stream(a, 1'b1, -1, -1, -1, 1'b0, a, "after_abort");

    for (int i = 0; i < int'(INUM); i++) a[i] = int'($urandom_range(0, 15));
    run_stream(a, 1'b1, -1, -1, 8, 1'b0, a, "rst_mid");
    run_stream(a, 1'b1, -1, -1, -1, 1'b0, a, "after_rst");

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < int'(INUM); i++) a[i] = int'($urandom_range(0, 15));
      run_stream(a, 1'b1, -1, -1, -1, 1'b0, a, $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
